instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 183 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns operation requests into 32-bit MIPS instruction words
// and buffers them in a two-entry FIFO. It also keeps a count of delivered
// words and a sticky flag for illegal operations.
module instr_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] instr_cnt,
  output logic        err,
  input  logic        err_clr
);

  // Operation codes as seen on in_op
  localparam logic [3:0] OP_ADDU = 4'd0;
  localparam logic [3:0] OP_SUBU = 4'd1;
  localparam logic [3:0] OP_JR   = 4'd2;
  localparam logic [3:0] OP_ORI  = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_LUI  = 4'd7;
  localparam logic [3:0] OP_JAL  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;

  // MIPS opcode and funct fields
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] OPC_RTYP = 6'b000000;
  localparam logic [5:0] OPC_ORI  = 6'b001101;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_LUI  = 6'b001111;
  localparam logic [5:0] OPC_JAL  = 6'b000011;
  localparam logic [5:0] OPC_J    = 6'b000010;

  // Build the instruction word; each op class uses only its own fields.
  function automatic logic [31:0] encode_instr(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    case (op)
      OP_ADDU: word = {OPC_RTYP, rs, rt, rd, 5'b00000, FN_ADDU};
      OP_SUBU: word = {OPC_RTYP, rs, rt, rd, 5'b00000, FN_SUBU};
      OP_JR:   word = {OPC_RTYP, rs, 5'b00000, 5'b00000, 5'b00000, FN_JR};
      OP_ORI:  word = {OPC_ORI, rs, rt, imm};
      OP_LW:   word = {OPC_LW, rs, rt, imm};
      OP_SW:   word = {OPC_SW, rs, rt, imm};
      OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
      OP_LUI:  word = {OPC_LUI, 5'b00000, rt, imm};
      OP_JAL:  word = {OPC_JAL, target};
      OP_J:    word = {OPC_J, target};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  // Codes 10..15 have no encoding.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_J);
  endfunction

  logic [31:0] slot0_r, slot1_r;
  logic        valid0_r, valid1_r;
  logic [31:0] slot0_nxt_s, slot1_nxt_s;
  logic        valid0_nxt_s, valid1_nxt_s;
  logic        push_s, pop_s;
  logic [31:0] enc_s;
  logic        illegal_s;
  logic        err_r;
  logic [15:0] cnt_r;

  // slot0 is always the head, so out_instr is a plain register output.
  assign in_ready  = ~valid1_r;
  assign out_valid = valid0_r;
  assign out_instr = slot0_r;
  assign instr_cnt = cnt_r;
  assign err       = err_r;

  assign push_s    = in_valid & ~valid1_r;
  assign pop_s     = valid0_r & out_ready;
  assign enc_s     = encode_instr(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
  assign illegal_s = op_illegal(in_op);

  // FIFO next state: push into the first free slot, pop shifts slot1 forward.
  always_comb begin
    slot0_nxt_s  = slot0_r;
    slot1_nxt_s  = slot1_r;
    valid0_nxt_s = valid0_r;
    valid1_nxt_s = valid1_r;
    case ({valid1_r, valid0_r})
      2'b00: begin
        if (push_s) begin
          slot0_nxt_s  = enc_s;
          valid0_nxt_s = 1'b1;
        end else begin
          valid0_nxt_s = 1'b0;
        end
      end
      2'b01: begin
        if (push_s && pop_s) begin
          slot0_nxt_s = enc_s;
        end else if (push_s) begin
          slot1_nxt_s  = enc_s;
          valid1_nxt_s = 1'b1;
        end else if (pop_s) begin
          valid0_nxt_s = 1'b0;
        end else begin
          valid0_nxt_s = 1'b1;
        end
      end
      2'b11: begin
        if (pop_s) begin
          slot0_nxt_s  = slot1_r;
          valid1_nxt_s = 1'b0;
        end else begin
          valid1_nxt_s = 1'b1;
        end
      end
      default: begin
        // slot1 valid without slot0 cannot occur; recover to empty.
        valid0_nxt_s = 1'b0;
        valid1_nxt_s = 1'b0;
      end
    endcase
  end

  // FIFO storage and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0_r  <= 32'h0000_0000;
      slot1_r  <= 32'h0000_0000;
      valid0_r <= 1'b0;
      valid1_r <= 1'b0;
    end else begin
      slot0_r  <= slot0_nxt_s;
      slot1_r  <= slot1_nxt_s;
      valid0_r <= valid0_nxt_s;
      valid1_r <= valid1_nxt_s;
    end
  end

  // Sticky illegal-op flag; a new illegal accept beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if (push_s && illegal_s) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  // Delivered-word counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= 16'h0000;
    end else if (pop_s) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed scenarios plus a randomized stream,
// all checked against a queue-based reference model.
module tb_instr_encoder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] instr_cnt;
  logic        err;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;
  bit quiet    = 1'b0;

  logic [31:0] q_m[$];
  logic [15:0] cnt_m;
  logic        err_m;

  instr_encoder dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .instr_cnt(instr_cnt),
    .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the instruction format tables, using arithmetic.
  function automatic logic [31:0] ref_enc(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] tgt, output bit ill);
    logic [31:0] r;
    ill = 1'b0;
    case (op)
      4'd0: r = (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + 32'd33;
      4'd1: r = (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + 32'd35;
      4'd2: r = (32'(rs) << 21) + 32'd8;
      4'd3: r = (32'd13 << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
      4'd4: r = (32'd35 << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
      4'd5: r = (32'd43 << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
      4'd6: r = (32'd4 << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
      4'd7: r = (32'd15 << 26) + (32'(rt) << 16) + 32'(imm);
      4'd8: r = (32'd3 << 26) + 32'(tgt);
      4'd9: r = (32'd2 << 26) + 32'(tgt);
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic check_outputs();
    chk("in_ready", 32'(in_ready), 32'(q_m.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q_m.size() != 0));
    if (q_m.size() != 0) chk("out_instr", out_instr, q_m[0]);
    chk("instr_cnt", 32'(instr_cnt), 32'(cnt_m));
    chk("err", 32'(err), 32'(err_m));
  endtask

  // One clock: check outputs, predict transfers, advance, update model.
  task automatic cycle();
    bit acc, pop, ill;
    logic [31:0] w;
    if (!quiet) check_outputs();
    acc = in_valid && (q_m.size() < 2);
    pop = out_ready && (q_m.size() != 0);
    w = ref_enc(in_op, in_rs, in_rt, in_rd, in_imm, in_target, ill);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q_m.pop_front());
      cnt_m = cnt_m + 16'd1;
    end
    if (acc) q_m.push_back(w);
    if (acc && ill) err_m = 1'b1;
    else if (err_clr) err_m = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] tgt);
    in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt;
  endtask

  task automatic model_reset();
    q_m.delete();
    cnt_m = 16'h0000;
    err_m = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_instr"}, out_instr, 32'd0);
    chk({tag, "_instr_cnt"}, 32'(instr_cnt), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    model_reset();
    #23;
    check_reset_state("reset");
    reset_n = 1'b1;
    #1;

    // Single ADDU, accepted on the first edge after reset release.
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF);
    cycle();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    chk("addu_word", out_instr, 32'h0022_1821);
    chk("addu_valid", 32'(out_valid), 32'd1);
    cycle();
    chk("addu_cnt", 32'(instr_cnt), 32'd1);

    // Back-to-back I-type stream.
    drive(1'b1, 4'd3, 5'd0, 5'd8, 5'd31, 16'h1234, 26'h155);
    cycle();
    chk("ori_word", out_instr, 32'h3408_1234);
    drive(1'b1, 4'd7, 5'd7, 5'd1, 5'd9, 16'hABCD, 26'h2AA);
    cycle();
    chk("lui_word", out_instr, 32'h3C01_ABCD);
    drive(1'b1, 4'd5, 5'd29, 5'd31, 5'd4, 16'hFFFC, 26'd0);
    cycle();
    chk("sw_word", out_instr, 32'hAFBF_FFFC);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    cycle();
    chk("stream_cnt", 32'(instr_cnt), 32'd4);

    // Fill FIFO with out_ready low, then drain.
    out_ready = 1'b0;
    drive(1'b1, 4'd8, 5'd5, 5'd6, 5'd7, 16'h1111, 26'h0000C00);
    cycle();
    drive(1'b1, 4'd9, 5'd5, 5'd6, 5'd7, 16'h2222, 26'h0100000);
    cycle();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("jal_hold", out_instr, 32'h0C00_0C00);
    cycle();
    chk("jal_hold2", out_instr, 32'h0C00_0C00);
    out_ready = 1'b1;
    cycle();
    chk("j_word", out_instr, 32'h0810_0000);
    cycle();
    chk("drained", 32'(out_valid), 32'd0);

    // Illegal op, set-wins-over-clear, then clear.
    drive(1'b1, 4'd12, 5'd3, 5'd3, 5'd3, 16'h5555, 26'h1);
    cycle();
    chk("ill_word", out_instr, 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    drive(1'b1, 4'd13, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    err_clr = 1'b1;
    cycle();
    chk("ill_setwins", 32'(err), 32'd1);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    cycle();
    err_clr = 1'b0;
    chk("ill_cleared", 32'(err), 32'd0);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 5'($urandom),
            5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      err_clr = 1'($urandom_range(0, 7) == 0);
      cycle();
    end
    err_clr = 1'b0;

    // Reset with two buffered words discards them.
    out_ready = 1'b0;
    drive(1'b1, 4'd4, 5'd1, 5'd2, 5'd3, 16'h0042, 26'd0);
    cycle();
    cycle();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("midrst");
    #3;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("no_stale", 32'(out_valid), 32'd0);
    end

    // Counter wrap: 65535 deliveries, then one more.
    drive(1'b1, 4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
    quiet = 1'b1;
    for (int i = 0; i < 70000 && cnt_m != 16'hFFFF; i++) cycle();
    quiet = 1'b0;
    chk("cnt_ffff", 32'(instr_cnt), 32'h0000_FFFF);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    cycle();
    chk("cnt_wrap", 32'(instr_cnt), 32'h0000_0000);
    cycle();
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
